// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core's memory stage and the data memory.
// Stores retire into a small FIFO in one cycle and drain whenever the memory port
// is not needed by a load. Loads always own the port and are forwarded from the
// youngest buffered store to the same word address.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   cpu_addr, cpu_wdata   word address / store data from the core
//   cpu_memread/memwrite  load / store request this cycle
//   cpu_rdata             load data (forwarded or from memory), combinational
//   stall                 core must hold the current store
//   empty                 no pending stores
//   mem_*                 data memory port (addr, wdata, read, write, rdata)
//   stall_cycles          saturating count of stalled cycles
module dmem_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 7,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_memread,
    input  logic          cpu_memwrite,
    output logic [DW-1:0] cpu_rdata,
    output logic          stall,
    output logic          empty,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stall_cycles
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);

    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [PW:0]      count_q;
    logic [15:0]      stall_cnt_q;

    logic full, pop, push;
    logic [PW-1:0] fwd_idx;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);

    // A load owns the port; otherwise the head drains whenever something is pending.
    assign pop   = ~cpu_memread & ~empty;
    // A same-cycle pop frees a slot, so only a non-draining full buffer stalls.
    assign stall = cpu_memwrite & full & ~pop;
    assign push  = cpu_memwrite & ~stall;

    assign mem_read     = cpu_memread;
    assign mem_write    = pop;
    assign mem_addr     = cpu_memread ? cpu_addr : addr_q[head_q];
    assign mem_wdata    = data_q[head_q];
    assign stall_cycles = stall_cnt_q;

    // Walk oldest to youngest so the youngest match is the one that sticks.
    always_comb begin
        cpu_rdata = mem_rdata;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if (((PW+1)'(i) < count_q) && valid_q[fwd_idx] && (addr_q[fwd_idx] == cpu_addr)) begin
                cpu_rdata = data_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // Clear before set: with push and pop on a full buffer, head == tail.
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= cpu_addr;
                data_q[tail_q]  <= cpu_wdata;
                tail_q          <= tail_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer with a behavioural 128x32 memory.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [6:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_memread;
    logic        cpu_memwrite;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        empty;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic [15:0] stall_cycles;

    logic [31:0] mem [128];
    wr_t         expq [$];  // writes expected at the memory port, in order
    wr_t         pend [$];  // model of buffer contents
    logic [15:0] mstall;
    int          n_cmp = 0;
    int          n_err = 0;

    dmem_store_buffer #(.DEPTH(DEPTH), .AW(7), .DW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_memread  (cpu_memread),
        .cpu_memwrite (cpu_memwrite),
        .cpu_rdata    (cpu_rdata),
        .stall        (stall),
        .empty        (empty),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Memory-side scoreboard: every write must match the oldest expected store.
    always @(negedge clk) begin
        if (!reset && mem_write) begin
            if (expq.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = expq.pop_front();
                check("wr_addr", {25'd0, mem_addr}, {25'd0, e.a});
                check("wr_data", mem_wdata, e.d);
            end
        end
    end

    // One core cycle: apply inputs, check combinational outputs, take the edge.
    task automatic drive(input logic [6:0] a, input logic [31:0] d, input logic rd,
                         input logic wr);
        logic        exp_pop, exp_stall;
        logic [31:0] exp_rd;
        wr_t         e;
        cpu_addr = a; cpu_wdata = d; cpu_memread = rd; cpu_memwrite = wr;
        #2;
        exp_pop   = !rd && (pend.size() != 0);
        exp_stall = wr && (pend.size() == DEPTH) && !exp_pop;
        check("stall", {31'd0, stall}, {31'd0, exp_stall});
        check("empty", {31'd0, empty}, {31'd0, pend.size() == 0});
        check("mem_read", {31'd0, mem_read}, {31'd0, rd});
        check("mem_write", {31'd0, mem_write}, {31'd0, exp_pop});
        check("stall_cycles", {16'd0, stall_cycles}, {16'd0, mstall});
        if (rd) begin
            exp_rd = mem[a];
            foreach (pend[i]) if (pend[i].a == a) exp_rd = pend[i].d;
            check("cpu_rdata", cpu_rdata, exp_rd);
            check("mem_addr_load", {25'd0, mem_addr}, {25'd0, a});
        end else if (exp_pop) begin
            check("mem_addr_drain", {25'd0, mem_addr}, {25'd0, pend[0].a});
        end
        @(posedge clk); #1;
        if (exp_pop) void'(pend.pop_front());
        if (wr && !exp_stall) begin
            e.a = a; e.d = d;
            pend.push_back(e);
            expq.push_back(e);
        end
        if (exp_stall && mstall != 16'hFFFF) mstall++;
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && pend.size() != 0; i++) drive(7'd0, 32'd0, 1'b0, 1'b0);
        drive(7'd0, 32'd0, 1'b0, 1'b0);  // confirms empty and no stray write
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'(i + 1);
        mstall = '0;
        reset = 1'b1; cpu_addr = 7'd2; cpu_wdata = '0; cpu_memread = 1'b1; cpu_memwrite = 1'b0;
        #3;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_mem_read", {31'd0, mem_read}, 32'd1);
        check("rst_stall_cycles", {16'd0, stall_cycles}, 32'd0);
        cpu_memread = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Single store drains on the next idle cycle.
        drive(7'd5, 32'h11, 1'b0, 1'b1);
        check("t1_mem_addr", {25'd0, mem_addr}, 32'd5);
        drive(7'd0, 32'd0, 1'b0, 1'b0);
        drive(7'd0, 32'd0, 1'b0, 1'b0);
        check("t1_mem5", mem[5], 32'h11);

        // Two stores to one address; load forwards the youngest.
        drive(7'd3, 32'hA, 1'b0, 1'b1);
        drive(7'd3, 32'hB, 1'b1, 1'b1);
        drive(7'd3, 32'd0, 1'b1, 1'b0);
        check("t2_fwd_young", cpu_rdata, 32'hB);
        drain();
        check("t2_mem3", mem[3], 32'hB);

        // Continuous loads fill the buffer; the fifth store stalls.
        for (int i = 0; i < 4; i++) drive(7'(10 + i), 32'(32'h100 + i), 1'b1, 1'b1);
        drive(7'd14, 32'h104, 1'b1, 1'b1);
        drive(7'd14, 32'h104, 1'b1, 1'b1);
        check("t3_stall_cnt", {16'd0, stall_cycles}, 32'd2);
        // Dropping the load lets the head drain and the held store push.
        drive(7'd14, 32'h104, 1'b0, 1'b1);
        // Still full: store plus drain again, exercising pointer wrap.
        drive(7'd15, 32'h105, 1'b0, 1'b1);
        drive(7'd13, 32'd0, 1'b1, 1'b0);
        drain();
        check("t3_mem15", mem[15], 32'h105);

        // Load with no matching entry reads memory directly.
        drive(7'd2, 32'd0, 1'b1, 1'b0);
        #2;
        cpu_addr = 7'd2; cpu_memread = 1'b1; #1;
        check("t5_miss_rdata", cpu_rdata, 32'd3);
        cpu_memread = 1'b0;
        @(posedge clk); #1;

        // Reset with three stores pending discards them.
        for (int i = 0; i < 3; i++) drive(7'(20 + i), 32'(32'h200 + i), 1'b1, 1'b1);
        cpu_memread = 1'b0; cpu_memwrite = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t6_empty", {31'd0, empty}, 32'd1);
        check("t6_mem_write", {31'd0, mem_write}, 32'd0);
        check("t6_stall_cycles", {16'd0, stall_cycles}, 32'd0);
        pend.delete(); expq.delete(); mstall = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) drive(7'd0, 32'd0, 1'b0, 1'b0);
        check("t6_mem20", mem[20], 32'd21);
        check("t6_expq", expq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
